seven_seg_mux_driver: RTL and testbench
=======================================

# seven_seg_mux_driver

Time-multiplexed driver for a parametrised bank of common-anode seven-segment digits. It generalises the single-digit hex decoder: it captures a packed multi-digit hex value through a load strobe and scans one digit per refresh slot. Each slot applies anti-ghosting dead time, optional leading-zero blanking and tear-free frame-boundary updates. It sits between core logic (keypad/counter datapath) and the FPGA pins that drive the segment lines and per-digit anode transistors.

## Interface
- NUM_DIGITS, 2: digits scanned, 1..8.
- REFRESH_DIV, 24000: clk cycles per digit slot, ≥ 4.
- DEAD_CYCLES, 64: cycles at slot start with all digits off, < REFRESH_DIV.
- ANODE_ACTIVE_LOW, 1: 1 = anode enable driven 0, 0 = driven 1.
- BLANK_LEADING_ZEROS, 0: 1 = suppress high-order zero digits.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- value  in  4*NUM_DIGITS  packed hex digits; digit i = value[4i+3:4i], digit 0 least significant.
- load  in  1  one-cycle strobe; captures value.
- enable  in  1  1 = scan; 0 = display dark, counters hold.
- segments  out  7  {a,b,c,d,e,f,g}, active low, registered.
- anodes  out  NUM_DIGITS  per-digit enable, polarity per ANODE_ACTIVE_LOW, registered.
- digit_idx  out  $clog2(NUM_DIGITS) (min 1)  digit currently in slot.
- frame_done  out  1  one-cycle pulse on last cycle of digit NUM_DIGITS-1 slot.

## Operation
- Segment encoding (active low), 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000. Blank = 1111111.
- Registers: shadow (4*NUM_DIGITS), pending flag, display (4*NUM_DIGITS), prescaler 0..REFRESH_DIV-1, digit_idx.
- load: shadow <= value, pending <= 1. A repeated load before frame boundary overwrites shadow; last one wins.
- Frame boundary = cycle where prescaler == REFRESH_DIV-1 and digit_idx == NUM_DIGITS-1. At that cycle:
  - If pending, display <= shadow and pending <= 0.
  - If load is in the same cycle, display <= value directly and pending <= 0.
- Scan states per slot: DEAD (prescaler < DEAD_CYCLES) -> ON (rest of slot).
  - At prescaler == REFRESH_DIV-1: prescaler <= 0, digit_idx <= digit_idx+1, wrapping NUM_DIGITS-1 -> 0.
- Output register, next value:
  - In DEAD: all anodes inactive, segments 1111111.
  - In ON: anodes[digit_idx] active only, segments = encode(display digit digit_idx).
- Leading-zero blanking (BLANK_LEADING_ZEROS=1): digit i (i>0) shows 1111111 when display digits i..NUM_DIGITS-1 are all 0. Digit 0 is never blanked, and its anode is still asserted.
- enable=0: prescaler and digit_idx hold; outputs all-inactive/1111111 from next cycle; frame_done 0. load and shadow capture still operate. The frame-boundary transfer does not occur while disabled.
- enable re-asserted: scan resumes from the held prescaler/digit_idx.

## Timing
- Reset (async assert, sync release):
  - segments = 1111111; anodes all inactive; digit_idx = 0; frame_done = 0.
  - prescaler = 0; shadow = display = 0; pending = 0.
- Output latency: segments/anodes reflect state one cycle late. First ON output appears DEAD_CYCLES+1 cycles after reset release.
- frame_done is registered and high for exactly one cycle, the cycle after the frame boundary. Period = NUM_DIGITS*REFRESH_DIV.
- load-to-visible: new value is never shown mid-frame. It first drives digit 0 in the frame following the next boundary.
- Reset mid-frame clears pending; a captured-but-unapplied value is lost.
- NUM_DIGITS=1: digit_idx stays 0, every slot end is a frame boundary.

## Test plan
- Reset: NUM_DIGITS=2, REFRESH_DIV=8, DEAD_CYCLES=1, active-low anodes; hold reset 3 cycles -> segments=1111111, anodes=11, frame_done=0. Release -> cycle 2 anodes=10 (digit 0), segments=0000001.
- Scan/wrap: load value=8'hA5 then run 3 frames -> after the boundary, digit 0 slots show 0100100 (5) with anodes=10, digit 1 slots show 0001000 (A) with anodes=01. Each slot starts with exactly 1 dark cycle. frame_done pulses every 16 cycles.
- Tear-free update: load 8'h12 mid-slot of digit 0 while showing 8'h34 -> digit 1 still shows 3 (0000110) this frame; 12 appears only after the next frame_done.
- Simultaneous load at boundary plus earlier pending load: load 8'h77, then load 8'h9C exactly on the boundary cycle -> next frame shows C/9 and pending clears. Also sweep all 16 codes and check the encoding list.
- Blanking: BLANK_LEADING_ZEROS=1, NUM_DIGITS=4, value=16'h0030 -> digits 3,2 = 1111111, digit 1 = 0000110, digit 0 = 0000001. value=0 -> only digit 0 lit with 0000001.
- enable/reset mid-op: deassert enable mid-slot -> next cycle anodes all inactive; counters frozen 10 cycles; re-enable resumes the same slot remainder. Assert reset mid-frame with pending load -> outputs dark immediately; after release display shows 0.

Source files
------------

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver.
// A load strobe captures a packed hex value into a shadow register.
// The shadow value moves to the display only at a frame boundary, so a frame never tears.
// Each digit slot starts with a dark dead-time window to suppress ghosting.
module seven_seg_mux_driver #(
  parameter int unsigned NUM_DIGITS          = 2,
  parameter int unsigned REFRESH_DIV         = 24000,
  parameter int unsigned DEAD_CYCLES         = 64,
  parameter bit          ANODE_ACTIVE_LOW    = 1'b1,
  parameter bit          BLANK_LEADING_ZEROS = 1'b0,
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    load_i,
  input  logic                    enable_i,
  output logic [6:0]              segments_o,
  output logic [NUM_DIGITS-1:0]   anodes_o,
  output logic [IdxW-1:0]         digit_idx_o,
  output logic                    frame_done_o
);

  localparam int unsigned PreW = $clog2(REFRESH_DIV);
  localparam int unsigned DigW = 4 * NUM_DIGITS;

  localparam logic [PreW-1:0]       PreLast  = PreW'(REFRESH_DIV - 1);
  localparam logic [PreW-1:0]       DeadEnd  = PreW'(DEAD_CYCLES);
  localparam logic [IdxW-1:0]       IdxLast  = IdxW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SegBlank = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] AnOff    = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

  typedef enum logic {StDead, StOn} phase_e;

  // Active-low {a,b,c,d,e,f,g} pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  logic [PreW-1:0]       prescaler_q, prescaler_d;
  logic [IdxW-1:0]       digit_idx_q, digit_idx_d;
  logic [DigW-1:0]       shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [DigW-1:0]       display_q, display_d;
  logic [6:0]            segments_q, segments_d;
  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic                  frame_done_q, frame_done_d;

  phase_e                phase;
  logic                  slot_end;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] onehot;
  logic [3:0]            cur_digit;

  // Slot phase and frame-boundary decode from the scan counters.
  always_comb begin
    phase    = (prescaler_q < DeadEnd) ? StDead : StOn;
    slot_end = (prescaler_q == PreLast);
    boundary = enable_i && slot_end && (digit_idx_q == IdxLast);
  end

  // Leading-zero mask: digit i blanks when it and every higher digit are zero; digit 0 never blanks.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (display_q[4*i +: 4] == 4'h0);
      blank[i]   = BLANK_LEADING_ZEROS && (i > 0) && upper_zero;
    end
  end

  // Shadow capture and tear-free transfer to the display register.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    display_d = display_q;
    if (load_i) begin
      shadow_d  = value_i;
      pending_d = 1'b1;
    end
    if (boundary) begin
      // A load landing on the boundary cycle wins over an older pending value.
      if (load_i) begin
        display_d = value_i;
      end else if (pending_q) begin
        display_d = shadow_q;
      end
      pending_d = 1'b0;
    end
  end

  // Scan counters advance only while enabled; disabling freezes the slot in place.
  always_comb begin
    prescaler_d = prescaler_q;
    digit_idx_d = digit_idx_q;
    if (enable_i) begin
      if (slot_end) begin
        prescaler_d = '0;
        digit_idx_d = (digit_idx_q == IdxLast) ? '0 : digit_idx_q + IdxW'(1);
      end else begin
        prescaler_d = prescaler_q + PreW'(1);
      end
    end
  end

  // Next output register value: dark in dead time or when disabled, else the current digit.
  always_comb begin
    onehot              = '0;
    onehot[digit_idx_q] = 1'b1;
    cur_digit           = display_q[{digit_idx_q, 2'b00} +: 4];
    segments_d          = SegBlank;
    anodes_d            = AnOff;
    frame_done_d        = 1'b0;
    if (enable_i) begin
      frame_done_d = boundary;
      if (phase == StOn) begin
        anodes_d   = ANODE_ACTIVE_LOW ? ~onehot : onehot;
        segments_d = blank[digit_idx_q] ? SegBlank : hex_to_seg(cur_digit);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescaler_q  <= '0;
      digit_idx_q  <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      display_q    <= '0;
      segments_q   <= SegBlank;
      anodes_q     <= AnOff;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      digit_idx_q  <= digit_idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      display_q    <= display_d;
      segments_q   <= segments_d;
      anodes_q     <= anodes_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign segments_o   = segments_q;
  assign anodes_o     = anodes_q;
  assign digit_idx_o  = digit_idx_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Bench for seven_seg_mux_driver: a 2-digit instance checked every cycle against a time-based
// reference model, plus a 4-digit blanking instance checked frame by frame from the digit rules.
module tb_seven_seg_mux_driver;

  localparam int RD  = 8;
  localparam int DC  = 1;
  localparam int NDA = 2;

  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] ENC [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0]  val_a  = '0;
  logic        load_a = 1'b0;
  logic        en_a   = 1'b1;
  logic [6:0]  seg_a;
  logic [1:0]  an_a;
  logic        idx_a;
  logic        fd_a;

  logic [15:0] val_b  = '0;
  logic        load_b = 1'b0;
  logic [6:0]  seg_b;
  logic [3:0]  an_b;
  logic [1:0]  idx_b;
  logic        fd_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seven_seg_mux_driver #(
    .NUM_DIGITS(2), .REFRESH_DIV(RD), .DEAD_CYCLES(DC),
    .ANODE_ACTIVE_LOW(1'b1), .BLANK_LEADING_ZEROS(1'b0)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .value_i(val_a), .load_i(load_a), .enable_i(en_a),
    .segments_o(seg_a), .anodes_o(an_a), .digit_idx_o(idx_a), .frame_done_o(fd_a)
  );

  seven_seg_mux_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(RD), .DEAD_CYCLES(DC),
    .ANODE_ACTIVE_LOW(1'b0), .BLANK_LEADING_ZEROS(1'b1)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .value_i(val_b), .load_i(load_b), .enable_i(1'b1),
    .segments_o(seg_b), .anodes_o(an_b), .digit_idx_o(idx_b), .frame_done_o(fd_b)
  );

  // Reference model for instance A: m_t counts enabled cycles since reset; slot and digit
  // follow from it arithmetically.
  int         m_t    = 0;
  logic [7:0] m_sh   = '0;
  logic       m_pend = 1'b0;
  logic [7:0] m_disp = '0;
  logic [6:0] m_seg  = BLK;
  logic [1:0] m_an   = 2'b11;
  logic       m_fd   = 1'b0;
  int         m_pre;
  int         m_idx;
  logic       m_bnd;

  assign m_pre = m_t % RD;
  assign m_idx = (m_t / RD) % NDA;
  assign m_bnd = en_a && (m_pre == RD - 1) && (m_idx == NDA - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_sh <= '0; m_pend <= 1'b0; m_disp <= '0;
      m_seg <= BLK; m_an <= 2'b11; m_fd <= 1'b0;
    end else begin
      m_fd <= m_bnd;
      if (en_a && m_pre >= DC) begin
        m_seg <= ENC[m_disp[m_idx*4 +: 4]];
        m_an  <= ~(2'b01 << m_idx);
      end else begin
        m_seg <= BLK;
        m_an  <= 2'b11;
      end
      if (m_bnd) begin
        m_disp <= load_a ? val_a : (m_pend ? m_sh : m_disp);
        m_pend <= 1'b0;
      end else if (load_a) begin
        m_pend <= 1'b1;
      end
      if (load_a) m_sh <= val_a;
      if (en_a) m_t <= m_t + 1;
    end
  end

  // Instance B frame tracking: b_k counts cycles after its frame_done pulse.
  int          b_k   = -1;
  bit          b_arm = 1'b0;
  logic [15:0] b_val = '0;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_b(input int k);
    int         p;
    int         i;
    logic [3:0] dig;
    logic [6:0] es;
    logic [3:0] ea;
    p   = (k - 1) % RD;
    i   = (k - 1) / RD;
    dig = 4'((b_val >> (4 * i)) & 16'hF);
    if (p < DC) begin
      es = BLK;
      ea = 4'b0000;
    end else begin
      ea = 4'b0001 << i;
      es = (i > 0 && (b_val >> (4 * i)) == 16'h0) ? BLK : ENC[dig];
    end
    cmp("b_seg", seg_b, es);
    cmp("b_an", an_b, ea);
    cmp("b_fd", fd_b, (k == 32));
  endtask

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cmp("a_seg", seg_a, m_seg);
      cmp("a_an", an_a, m_an);
      cmp("a_fd", fd_a, m_fd);
      cmp("a_idx", idx_a, m_idx);
      if (b_k >= 1) begin
        check_b(b_k);
        b_k = (b_k == 32) ? -1 : b_k + 1;
      end
      if (b_arm && fd_b) begin
        b_arm = 1'b0;
        b_k   = 1;
      end
    end
  endtask

  task automatic wait_fd_a(input string tag);
    int n;
    n = 0;
    tick(1);
    while (!fd_a && n < 40) begin
      tick(1);
      n++;
    end
    cmp(tag, fd_a, 1'b1);
  endtask

  task automatic load_a_val(input logic [7:0] v);
    val_a  = v;
    load_a = 1'b1;
    tick(1);
    load_a = 1'b0;
  endtask

  task automatic run_b(input logic [15:0] v, input string tag);
    val_b  = v;
    b_val  = v;
    load_b = 1'b1;
    tick(1);
    load_b = 1'b0;
    b_arm  = 1'b1;
    tick(70);
    cmp(tag, (b_arm == 1'b0) && (b_k == -1), 1'b1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    tick(3);
    cmp("rst_seg", seg_a, BLK);
    cmp("rst_an", an_a, 2'b11);
    cmp("rst_fd", fd_a, 1'b0);
    cmp("rst_an_b", an_b, 4'b0000);
    rst_n = 1'b1;
    tick(1);
    cmp("first_dark", an_a, 2'b11);
    tick(1);
    cmp("first_on_an", an_a, 2'b10);
    cmp("first_on_seg", seg_a, 7'b0000001);

    // Scan and wrap with A5.
    load_a_val(8'hA5);
    wait_fd_a("fd_a5");
    tick(2);
    cmp("a5_d0_seg", seg_a, 7'b0100100);
    cmp("a5_d0_an", an_a, 2'b10);
    tick(8);
    cmp("a5_d1_seg", seg_a, 7'b0001000);
    cmp("a5_d1_an", an_a, 2'b01);
    wait_fd_a("fd_a5_b");
    n = 0;
    tick(1);
    n++;
    while (!fd_a && n < 40) begin
      tick(1);
      n++;
    end
    cmp("fd_period", n, 16);

    // Tear-free update.
    load_a_val(8'h34);
    wait_fd_a("fd_34");
    tick(3);
    load_a_val(8'h12);
    tick(6);
    cmp("tear_d1_still_3", seg_a, 7'b0000110);
    wait_fd_a("fd_12");
    tick(2);
    cmp("new_d0_2", seg_a, 7'b0010010);
    tick(8);
    cmp("new_d1_1", seg_a, 7'b1001111);

    // Pending load followed by a load exactly on the boundary cycle.
    wait_fd_a("fd_pre_bnd");
    tick(2);
    load_a_val(8'h77);
    tick(12);
    val_a  = 8'h9C;
    load_a = 1'b1;
    tick(1);
    cmp("bnd_fd", fd_a, 1'b1);
    load_a = 1'b0;
    tick(2);
    cmp("bnd_d0_C", seg_a, 7'b0110001);
    tick(8);
    cmp("bnd_d1_9", seg_a, 7'b0000100);
    wait_fd_a("fd_after_bnd");
    tick(2);
    cmp("bnd_hold_C", seg_a, 7'b0110001);

    // Sweep all sixteen codes two digits at a time.
    for (int d = 0; d < 16; d += 2) begin
      load_a_val({4'(d + 1), 4'(d)});
      wait_fd_a("fd_sweep");
      tick(2);
      cmp("sweep_lo", seg_a, ENC[d]);
      tick(8);
      cmp("sweep_hi", seg_a, ENC[d+1]);
    end

    // Enable dropped mid-slot, counters frozen, then resumed.
    wait_fd_a("fd_en");
    tick(3);
    en_a = 1'b0;
    tick(1);
    cmp("dis_an", an_a, 2'b11);
    cmp("dis_seg", seg_a, BLK);
    tick(10);
    cmp("dis_idx_held", idx_a, 1'b0);
    en_a = 1'b1;
    tick(40);

    // Leading-zero blanking on the 4-digit instance.
    run_b(16'h0030, "b_done_0030");
    run_b(16'h0000, "b_done_0000");
    run_b(16'h0105, "b_done_0105");
    run_b(16'($urandom), "b_done_rand");

    // Randomized loads and enable drops against the model.
    for (int r = 0; r < 40; r++) begin
      val_a  = 8'($urandom);
      load_a = ($urandom_range(0, 2) == 0);
      en_a   = ($urandom_range(0, 5) != 0);
      tick(1);
      load_a = 1'b0;
      tick($urandom_range(0, 12));
    end
    en_a = 1'b1;
    tick(40);

    // Reset mid-frame drops a pending load.
    wait_fd_a("fd_rst");
    tick(3);
    load_a_val(8'hEE);
    #2 rst_n = 1'b0;
    #1;
    cmp("rst_mid_seg", seg_a, BLK);
    cmp("rst_mid_an", an_a, 2'b11);
    cmp("rst_mid_fd", fd_a, 1'b0);
    cmp("rst_mid_idx", idx_a, 1'b0);
    tick(2);
    rst_n = 1'b1;
    wait_fd_a("fd_post_rst");
    tick(2);
    cmp("post_rst_d0", seg_a, 7'b0000001);
    tick(8);
    cmp("post_rst_d1", seg_a, 7'b0000001);
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
